// File: rtl/alu_dispatch.sv
// Execute-stage sequencer: decodes one RV32I OP / OP-IMM / LUI word, reads rs1/rs2 through a
// single synchronous register-file port, drives the ALU and writes its result back to rd.

package alu_dispatch_pkg;
    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_operation_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_RS1,
        ST_READ_RS2,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_FAULT
    } dispatch_state_t;

    typedef enum logic [1:0] {
        KIND_OP,
        KIND_OP_IMM,
        KIND_LUI
    } instr_kind_t;
endpackage

// Instruction handshake: a word transfers on a rising edge where instruction_valid and
// instruction_ready are both high; ready is high only in IDLE, and the word is decoded on that edge.
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter bit ENABLE_LUI             = 1'b1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              instruction_valid,
    output logic                              instruction_ready,
    input  logic [31:0]                       instruction,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] register_read_address,
    input  logic [31:0]                       register_read_data,
    output logic                              register_write_enable,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] register_write_address,
    output logic [31:0]                       register_write_data,
    output alu_operation_t                    alu_operation,
    output logic signed [31:0]                alu_operand_1,
    output logic signed [31:0]                alu_operand_2,
    input  logic signed [31:0]                alu_result,
    output logic                              retire_valid,
    output logic                              illegal_instruction,
    output dispatch_state_t                   debug_state
);
    localparam int RAW = REGISTER_ADDRESS_WIDTH;
    localparam logic [31:0] REGISTER_COUNT = 32'd1 << RAW;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;

    dispatch_state_t state_q, state_d;
    instr_kind_t     kind_q, kind_d;
    alu_operation_t  operation_q, operation_d;
    logic [RAW-1:0]  read_address_q, read_address_d;
    logic [RAW-1:0]  write_address_q, write_address_d;
    logic [RAW-1:0]  rs2_q, rs2_d;
    logic            rs1_zero_q, rs1_zero_d;
    logic [19:0]     upper_q, upper_d;
    logic [31:0]     operand_1_q, operand_1_d;
    logic [31:0]     operand_2_q, operand_2_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1_field;
    logic [4:0]      rs2_field;
    logic [4:0]      rd_field;
    alu_operation_t  dec_operation;
    instr_kind_t     dec_kind;
    logic            dec_illegal;

    assign opcode    = instruction[6:0];
    assign rd_field  = instruction[11:7];
    assign funct3    = instruction[14:12];
    assign rs1_field = instruction[19:15];
    assign rs2_field = instruction[24:20];
    assign funct7    = instruction[31:25];

    function automatic logic out_of_range(input logic [4:0] index);
        return {27'd0, index} >= REGISTER_COUNT;
    endfunction

    function automatic alu_operation_t funct3_operation(input logic [2:0] f3,
                                                        input logic alt_sub,
                                                        input logic alt_sra);
        case (f3)
            3'b000:  return alt_sub ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt_sra ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // On OP-IMM the funct7 position is imm[11:5]; it only selects/validates for the shifts.
    always_comb begin
        dec_operation = ALU_ADD;
        dec_kind      = KIND_OP;
        dec_illegal   = 1'b0;
        case (opcode)
            OPCODE_OP: begin
                dec_kind      = KIND_OP;
                dec_operation = funct3_operation(funct3, funct7[5], funct7[5]);
                if (funct7 == FUNCT7_ALT) begin
                    dec_illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
                end else begin
                    dec_illegal = (funct7 != 7'b0000000);
                end
                dec_illegal = dec_illegal | out_of_range(rs1_field)
                            | out_of_range(rs2_field) | out_of_range(rd_field);
            end
            OPCODE_OP_IMM: begin
                dec_kind      = KIND_OP_IMM;
                dec_operation = funct3_operation(funct3, 1'b0, funct7[5]);
                if (funct3 == 3'b001) begin
                    dec_illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    dec_illegal = (funct7 != 7'b0000000) && (funct7 != FUNCT7_ALT);
                end
                dec_illegal = dec_illegal | out_of_range(rs1_field) | out_of_range(rd_field);
            end
            OPCODE_LUI: begin
                dec_kind      = KIND_LUI;
                dec_operation = ALU_ADD;
                dec_illegal   = !ENABLE_LUI | out_of_range(rd_field);
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        kind_d          = kind_q;
        operation_d     = operation_q;
        read_address_d  = read_address_q;
        write_address_d = write_address_q;
        rs2_d           = rs2_q;
        rs1_zero_d      = rs1_zero_q;
        upper_d         = upper_q;
        operand_1_d     = operand_1_q;
        operand_2_d     = operand_2_q;
        case (state_q)
            ST_IDLE: begin
                if (instruction_valid) begin
                    if (dec_illegal) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d         = ST_READ_RS1;
                        kind_d          = dec_kind;
                        operation_d     = dec_operation;
                        read_address_d  = instruction[15 +: RAW];
                        write_address_d = instruction[7 +: RAW];
                        rs2_d           = instruction[20 +: RAW];
                        rs1_zero_d      = (rs1_field == 5'd0);
                        upper_d         = instruction[31:12];
                    end
                end
            end
            ST_READ_RS1: begin
                state_d        = ST_READ_RS2;
                read_address_d = rs2_q;
            end
            ST_READ_RS2: begin
                state_d     = ST_EXECUTE;
                operand_1_d = (kind_q == KIND_LUI || rs1_zero_q) ? 32'd0 : register_read_data;
            end
            ST_EXECUTE: begin
                state_d = ST_WRITEBACK;
                case (kind_q)
                    KIND_OP_IMM: operand_2_d = {{20{upper_q[19]}}, upper_q[19:8]};
                    KIND_LUI:    operand_2_d = {upper_q, 12'd0};
                    default:     operand_2_d = (read_address_q == '0) ? 32'd0 : register_read_data;
                endcase
            end
            ST_WRITEBACK: state_d = ST_IDLE;
            ST_FAULT:     state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            kind_q          <= KIND_OP;
            operation_q     <= ALU_ADD;
            read_address_q  <= '0;
            write_address_q <= '0;
            rs2_q           <= '0;
            rs1_zero_q      <= 1'b0;
            upper_q         <= '0;
            operand_1_q     <= '0;
            operand_2_q     <= '0;
        end else begin
            state_q         <= state_d;
            kind_q          <= kind_d;
            operation_q     <= operation_d;
            read_address_q  <= read_address_d;
            write_address_q <= write_address_d;
            rs2_q           <= rs2_d;
            rs1_zero_q      <= rs1_zero_d;
            upper_q         <= upper_d;
            operand_1_q     <= operand_1_d;
            operand_2_q     <= operand_2_d;
        end
    end

    // Pulses are masked while reset is high so a reset in the final cycle never commits.
    assign instruction_ready      = (state_q == ST_IDLE);
    assign register_write_enable  = (state_q == ST_WRITEBACK) && (write_address_q != '0) && !reset;
    assign retire_valid           = (state_q == ST_WRITEBACK) && !reset;
    assign illegal_instruction    = (state_q == ST_FAULT) && !reset;
    assign register_read_address  = read_address_q;
    assign register_write_address = write_address_q;
    assign register_write_data    = alu_result;
    assign alu_operation          = operation_q;
    assign alu_operand_1          = operand_1_q;
    assign alu_operand_2          = operand_2_q;
    assign debug_state            = state_q;
endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: a RV32I instance and a RV32E instance, each with a register-file
// and ALU model, directed instructions and an expected-event scoreboard with timing.
module tb_alu_dispatch;
    import alu_dispatch_pkg::*;

    localparam int EW = 55;  // {cycle[15:0], kind[1:0], addr[4:0], data[31:0]}
    localparam logic [1:0] K_WRITE   = 2'd1;
    localparam logic [1:0] K_NOWRITE = 2'd2;
    localparam logic [1:0] K_ILLEGAL = 2'd3;

    logic        clock = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic [EW-1:0] exp5_q[$];
    logic [EW-1:0] exp4_q[$];

    // RV32I instance
    logic            valid5, ready5, we5, ret5, ill5;
    logic [31:0]     instr5, rdata5, wd5, a5, b5, res5;
    logic [4:0]      ra5, wa5;
    alu_operation_t  op5;
    dispatch_state_t st5;

    // RV32E instance
    logic            valid4, ready4, we4, ret4, ill4;
    logic [31:0]     instr4, rdata4, wd4, a4, b4, res4;
    logic [3:0]      ra4, wa4;
    alu_operation_t  op4;
    dispatch_state_t st4;

    alu_dispatch #(.REGISTER_ADDRESS_WIDTH(5)) dut5 (
        .clock(clock), .reset(reset),
        .instruction_valid(valid5), .instruction_ready(ready5), .instruction(instr5),
        .register_read_address(ra5), .register_read_data(rdata5),
        .register_write_enable(we5), .register_write_address(wa5), .register_write_data(wd5),
        .alu_operation(op5), .alu_operand_1(a5), .alu_operand_2(b5), .alu_result(res5),
        .retire_valid(ret5), .illegal_instruction(ill5), .debug_state(st5)
    );

    alu_dispatch #(.REGISTER_ADDRESS_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset),
        .instruction_valid(valid4), .instruction_ready(ready4), .instruction(instr4),
        .register_read_address(ra4), .register_read_data(rdata4),
        .register_write_enable(we4), .register_write_address(wa4), .register_write_data(wd4),
        .alu_operation(op4), .alu_operand_1(a4), .alu_operand_2(b4), .alu_result(res4),
        .retire_valid(ret4), .illegal_instruction(ill4), .debug_state(st4)
    );

    function automatic logic [31:0] alu_model(input alu_operation_t op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'd0;
        endcase
    endfunction

    assign res5 = alu_model(op5, a5, b5);
    assign res4 = alu_model(op4, a4, b4);

    // Register-file models: x0 of the RV32I file holds junk to exercise the x0 forcing.
    logic [31:0] regs5 [32];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clock) begin
        if (pl_en) regs5[pl_addr] <= pl_data;
        else if (we5) regs5[wa5] <= wd5;
        rdata5 <= regs5[ra5];
    end

    always @(posedge clock) rdata4 <= 32'h100 + {28'd0, ra4};

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitors
    always @(negedge clock) begin
        logic [EW-1:0] act;
        logic [1:0] kind;
        if (!reset && (ret5 || ill5)) begin
            kind = (ill5 && !ret5) ? K_ILLEGAL : (ret5 && !ill5) ? (we5 ? K_WRITE : K_NOWRITE) : 2'd0;
            act  = {16'(cyc), kind, we5 ? wa5 : 5'd0, we5 ? wd5 : 32'd0};
            if (exp5_q.size() == 0) begin
                n_checks++;
                $display("FAIL dut5 unexpected event: got %h expected none", act);
            end else begin
                check("dut5 event", 64'(act), 64'(exp5_q.pop_front()));
            end
        end
        if (!reset && we5 && !ret5) begin
            n_checks++;
            $display("FAIL dut5 stray write: got addr %0d data %h expected no write", wa5, wd5);
        end
    end

    always @(negedge clock) begin
        logic [EW-1:0] act;
        logic [1:0] kind;
        if (!reset && (ret4 || ill4)) begin
            kind = (ill4 && !ret4) ? K_ILLEGAL : (ret4 && !ill4) ? (we4 ? K_WRITE : K_NOWRITE) : 2'd0;
            act  = {16'(cyc), kind, we4 ? {1'b0, wa4} : 5'd0, we4 ? wd4 : 32'd0};
            if (exp4_q.size() == 0) begin
                n_checks++;
                $display("FAIL dut4 unexpected event: got %h expected none", act);
            end else begin
                check("dut4 event", 64'(act), 64'(exp4_q.pop_front()));
            end
        end
        if (!reset && we4 && !ret4) begin
            n_checks++;
            $display("FAIL dut4 stray write: got addr %0d data %h expected no write", wa4, wd4);
        end
    end

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    function automatic logic ready_of(input int dut);
        return (dut == 5) ? ready5 : ready4;
    endfunction

    task automatic drive(input int dut, input logic v, input logic [31:0] ins);
        if (dut == 5) begin valid5 = v; instr5 = ins; end
        else begin valid4 = v; instr4 = ins; end
    endtask

    task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    // Waits for ready, hands over one word, queues its expected event and checks ready returns on time.
    task automatic issue(input int dut, input logic [31:0] ins, input logic [1:0] kind,
                         input logic [4:0] addr, input logic [31:0] data);
        int waited;
        int unsigned t;
        int unsigned lat;
        waited = 0;
        @(negedge clock);
        while (!ready_of(dut) && waited < 50) begin @(negedge clock); waited++; end
        if (!ready_of(dut)) begin
            n_checks++;
            $display("FAIL dut%0d ready timeout before issue: got 0 expected 1", dut);
            return;
        end
        drive(dut, 1'b1, ins);
        @(posedge clock);
        #1;
        t = cyc;
        drive(dut, 1'b0, 32'd0);
        lat = (kind == K_ILLEGAL) ? 1 : 4;
        if (dut == 5) exp5_q.push_back({16'(t + lat - 1), kind, addr, data});
        else exp4_q.push_back({16'(t + lat - 1), kind, addr, data});
        waited = 0;
        @(negedge clock);
        while (!ready_of(dut) && waited < 50) begin @(negedge clock); waited++; end
        check($sformatf("dut%0d ready return cycle", dut), 64'(cyc), 64'(t + lat));
    endtask

    initial begin
        int unsigned t;
        reset = 1'b1;
        valid5 = 1'b0; instr5 = '0;
        valid4 = 1'b0; instr4 = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset ready5", 64'(ready5), 64'd1);
        check("reset ready4", 64'(ready4), 64'd1);
        check("reset we5", 64'(we5), 64'd0);
        check("reset retire5", 64'(ret5), 64'd0);
        check("reset illegal5", 64'(ill5), 64'd0);
        check("reset alu op5", 64'(op5), 64'(ALU_ADD));
        check("reset operand1", 64'(a5), 64'd0);
        check("reset operand2", 64'(b5), 64'd0);
        check("reset read addr", 64'(ra5), 64'd0);
        check("reset write addr", 64'(wa5), 64'd0);
        check("reset state", 64'(st5), 64'(ST_IDLE));

        set_reg(5'd0, 32'hDEADBEEF);
        for (int i = 1; i < 32; i++) set_reg(5'(i), 32'h1000 + i);

        set_reg(5'd1, 32'd5);
        set_reg(5'd2, 32'd7);
        issue(5, r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), K_WRITE, 5'd3, 32'h0000000C);
        issue(5, r_type(7'h00, 5'd2, 5'd0, 3'b000, 5'd8), K_WRITE, 5'd8, 32'h00000007);

        issue(4, r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), K_WRITE, 5'd3, 32'h00000203);
        issue(4, r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd16), K_ILLEGAL, 5'd0, 32'd0);
        issue(4, r_type(7'h00, 5'd17, 5'd1, 3'b000, 5'd3), K_ILLEGAL, 5'd0, 32'd0);

        set_reg(5'd1, 32'd3);
        set_reg(5'd2, 32'd5);
        issue(5, r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd5), K_WRITE, 5'd5, 32'hFFFFFFFE);
        issue(5, r_type(7'h00, 5'd1, 5'd5, 3'b011, 5'd6), K_WRITE, 5'd6, 32'h00000000);
        issue(5, r_type(7'h00, 5'd1, 5'd5, 3'b010, 5'd6), K_WRITE, 5'd6, 32'h00000001);
        issue(5, r_type(7'h00, 5'd2, 5'd1, 3'b100, 5'd9), K_WRITE, 5'd9, 32'h00000006);
        issue(5, r_type(7'h01, 5'd2, 5'd1, 3'b000, 5'd3), K_ILLEGAL, 5'd0, 32'd0);
        issue(5, 32'hFFFFFFFF, K_ILLEGAL, 5'd0, 32'd0);

        set_reg(5'd1, 32'h80000000);
        issue(5, i_type(12'h404, 5'd1, 3'b101, 5'd4), K_WRITE, 5'd4, 32'hF8000000);
        issue(5, i_type(12'h004, 5'd1, 3'b101, 5'd4), K_WRITE, 5'd4, 32'h08000000);
        issue(5, i_type(12'h404, 5'd1, 3'b001, 5'd4), K_ILLEGAL, 5'd0, 32'd0);
        issue(5, i_type(12'h001, 5'd1, 3'b000, 5'd0), K_NOWRITE, 5'd0, 32'd0);
        issue(5, i_type(12'hFFF, 5'd1, 3'b111, 5'd9), K_WRITE, 5'd9, 32'h80000000);
        issue(5, u_type(20'hABCDE, 5'd7), K_WRITE, 5'd7, 32'hABCDE000);

        // Reset while an ADD x10 sits in EXECUTE: no write, no retire, straight back to IDLE.
        @(negedge clock);
        valid5 = 1'b1;
        instr5 = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd10);
        @(posedge clock);
        #1;
        t = cyc;
        valid5 = 1'b0;
        instr5 = '0;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("state before reset", 64'(st5), 64'(ST_EXECUTE));
        check("cycle before reset", 64'(cyc), 64'(t + 2));
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("ready after reset", 64'(ready5), 64'd1);
        check("state after reset", 64'(st5), 64'(ST_IDLE));
        repeat (6) @(negedge clock);
        check("x10 untouched", 64'(regs5[10]), 64'h0000100A);

        issue(5, r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd11), K_WRITE, 5'd11, 32'h80000005);

        repeat (3) @(negedge clock);
        check("dut5 queue drained", 64'(exp5_q.size()), 64'd0);
        check("dut4 queue drained", 64'(exp4_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
